// File: rtl/rsa_word_deserializer.sv
// rtl/rsa_word_deserializer.sv - assembles msg/key/modulus operand frames from a host word stream
// Words arrive msg first, then key, then modulus, least-significant word first within each field.
module rsa_word_deserializer #(
  parameter int MOD_WIDTH  = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [MOD_WIDTH-1:0]  o_msg,
  output logic [MOD_WIDTH-1:0]  o_key,
  output logic [MOD_WIDTH-1:0]  o_modulus,
  output logic                  o_err
);

  localparam int N      = MOD_WIDTH / WORD_WIDTH;
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  generate
    if (MOD_WIDTH % WORD_WIDTH != 0) begin : g_bad_width
      $error("MOD_WIDTH must be a multiple of WORD_WIDTH");
    end
  endgenerate

  logic [0:0]        state;
  logic [1:0]        field;
  logic [SLOT_W-1:0] slot;
  logic              accept;
  logic              final_word;

  // o_valid comes straight from the state flop so an async reset drops it at once.
  assign i_ready    = !rst && (state == COLLECT);
  assign o_valid    = (state == HOLD);
  assign accept     = i_valid && i_ready;
  assign final_word = (field == 2'd2) && (slot == SLOT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      field     <= 2'd0;
      slot      <= '0;
      o_err     <= 1'b0;
      o_msg     <= '0;
      o_key     <= '0;
      o_modulus <= '0;
    end else begin
      o_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            case (field)
              2'd0:    o_msg[int'(slot) * WORD_WIDTH +: WORD_WIDTH]     <= i_word;
              2'd1:    o_key[int'(slot) * WORD_WIDTH +: WORD_WIDTH]     <= i_word;
              default: o_modulus[int'(slot) * WORD_WIDTH +: WORD_WIDTH] <= i_word;
            endcase
            if (final_word && i_last) begin
              state <= HOLD;
              field <= 2'd0;
              slot  <= '0;
            end else if (final_word || i_last) begin
              // Mis-framed: drop the frame; partial data regs are left as don't-care.
              o_err <= 1'b1;
              field <= 2'd0;
              slot  <= '0;
            end else if (slot == SLOT_W'(N - 1)) begin
              slot  <= '0;
              field <= field + 2'd1;
            end else begin
              slot <= slot + SLOT_W'(1);
            end
          end
        end
        default: begin
          if (o_ready) begin
            state <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_word_deserializer.sv
// tb/tb_rsa_word_deserializer.sv - directed self-checking bench for rsa_word_deserializer
module tb_rsa_word_deserializer;

  localparam int MW = 256;
  localparam int WW = 32;
  localparam int N  = MW / WW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [WW-1:0] i_word;
  logic          i_last;
  logic          o_valid;
  logic          o_ready;
  logic [MW-1:0] o_msg;
  logic [MW-1:0] o_key;
  logic [MW-1:0] o_modulus;
  logic          o_err;

  int total = 0;
  int bad   = 0;

  rsa_word_deserializer #(.MOD_WIDTH(MW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_word(i_word), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_msg(o_msg), .o_key(o_key), .o_modulus(o_modulus), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Field f of a frame whose word k carries base+k+1.
  function automatic logic [MW-1:0] exp_field(input int base, input int f);
    logic [MW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'(base + f*N + i + 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams nwords words (base+k+1), i_last on word last_at (-1 = never).
  task automatic send_frame(input int base, input int nwords, input int last_at, output bit timeout);
    timeout = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      int cnt;
      i_valid = 1'b1;
      i_word  = WW'(base + k + 1);
      i_last  = (k == last_at);
      cnt = 0;
      while (!i_ready && cnt < 50) begin
        tick();
        cnt++;
      end
      if (cnt >= 50) timeout = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic release_output();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_word = '0; i_last = 1'b0; o_ready = 1'b0;
    tick(); tick();
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL reset_i_ready got=%b want=0", i_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_o_err got=%b want=0", o_err); end
    total++; if ({o_msg, o_key, o_modulus} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", o_msg); end
    rst = 1'b0;
    tick();
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL post_reset_i_ready got=%b want=1", i_ready); end
  endtask

  task automatic test_single_frame();
    bit to;
    send_frame(0, 3*N, 3*N-1, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", to); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_o_valid got=%b want=1", o_valid); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL single_o_err got=%b want=0", o_err); end
    total++; if (o_msg !== exp_field(0, 0)) begin bad++; $display("FAIL single_msg got=%h want=%h", o_msg, exp_field(0, 0)); end
    total++; if (o_key !== exp_field(0, 1)) begin bad++; $display("FAIL single_key got=%h want=%h", o_key, exp_field(0, 1)); end
    total++; if (o_modulus !== exp_field(0, 2)) begin bad++; $display("FAIL single_modulus got=%h want=%h", o_modulus, exp_field(0, 2)); end
  endtask

  task automatic test_backpressure();
    bit to;
    i_valid = 1'b1; i_word = 32'hDEAD_BEEF; i_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_o_valid cyc=%0d got=%b want=1", c, o_valid); end
      total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL bp_i_ready cyc=%0d got=%b want=0", c, i_ready); end
      total++; if ({o_msg, o_key, o_modulus} !== {exp_field(0, 0), exp_field(0, 1), exp_field(0, 2)}) begin
        bad++; $display("FAIL bp_stable cyc=%0d msg=%h", c, o_msg);
      end
    end
    i_valid = 1'b0; i_last = 1'b0;
    release_output();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_release_o_valid got=%b want=0", o_valid); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL bp_release_i_ready got=%b want=1", i_ready); end
    // Any word swallowed during HOLD would skew this frame by one slot.
    send_frame(40, 3*N, 3*N-1, to);
    total++; if ({o_msg, o_key, o_modulus} !== {exp_field(40, 0), exp_field(40, 1), exp_field(40, 2)}) begin
      bad++; $display("FAIL bp_next_frame msg=%h want=%h", o_msg, exp_field(40, 0));
    end
    release_output();
  endtask

  task automatic test_early_last();
    bit to;
    send_frame(60, 6, 5, to);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL early_o_err got=%b want=1", o_err); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL early_o_valid got=%b want=0", o_valid); end
    tick();
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL early_o_err_width got=%b want=0", o_err); end
    send_frame(100, 3*N, 3*N-1, to);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL early_next_o_valid got=%b want=1", o_valid); end
    total++; if ({o_msg, o_key, o_modulus} !== {exp_field(100, 0), exp_field(100, 1), exp_field(100, 2)}) begin
      bad++; $display("FAIL early_next_data msg=%h want=%h", o_msg, exp_field(100, 0));
    end
    release_output();
  endtask

  task automatic test_missing_last();
    bit to;
    send_frame(150, 3*N, -1, to);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL missing_o_err got=%b want=1", o_err); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL missing_o_valid got=%b want=0", o_valid); end
    tick();
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL missing_o_err_width got=%b want=0", o_err); end
    send_frame(200, 3*N, 3*N-1, to);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL missing_next_o_valid got=%b want=1", o_valid); end
    total++; if ({o_msg, o_key, o_modulus} !== {exp_field(200, 0), exp_field(200, 1), exp_field(200, 2)}) begin
      bad++; $display("FAIL missing_next_data msg=%h want=%h", o_msg, exp_field(200, 0));
    end
    release_output();
  endtask

  task automatic test_back_to_back();
    int k = 0, f = 0, nvalid = 0, nlow = 0, last_rise = -1;
    o_ready = 1'b1;
    i_valid = 1'b1; i_word = WW'(1000 + 1); i_last = 1'b0;
    for (int c = 0; c < 90; c++) begin
      bit acc;
      acc = i_valid && i_ready;
      tick();
      if (acc) begin
        k++;
        if (k == 3*N) begin k = 0; f++; end
      end
      i_valid = (f < 3);
      i_word  = WW'(1000*(f+1) + k + 1);
      i_last  = (k == 3*N-1);
      if (f < 3 || o_valid) begin
        if (!i_ready) nlow++;
      end
      if (o_valid) begin
        int b;
        b = 1000*nvalid + 1000;
        total++; if ({o_msg, o_key, o_modulus} !== {exp_field(b, 0), exp_field(b, 1), exp_field(b, 2)}) begin
          bad++; $display("FAIL stream_data frame=%0d msg=%h want=%h", nvalid, o_msg, exp_field(b, 0));
        end
        if (last_rise >= 0) begin
          total++; if (c - last_rise !== 3*N+1) begin bad++; $display("FAIL stream_period got=%0d want=%0d", c - last_rise, 3*N+1); end
        end
        last_rise = c;
        nvalid++;
      end
    end
    i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b0;
    total++; if (nvalid !== 3) begin bad++; $display("FAIL stream_count got=%0d want=3", nvalid); end
    total++; if (nlow !== 3) begin bad++; $display("FAIL stream_i_ready_low got=%0d want=3", nlow); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    send_frame(300, 10, -1, to);
    rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_o_valid got=%b want=0", o_valid); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL midrst_o_err got=%b want=0", o_err); end
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL midrst_i_ready got=%b want=0", i_ready); end
    tick();
    rst = 1'b0;
    tick();
    send_frame(500, 3*N, 3*N-1, to);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL midrst_next_o_valid got=%b want=1", o_valid); end
    total++; if ({o_msg, o_key, o_modulus} !== {exp_field(500, 0), exp_field(500, 1), exp_field(500, 2)}) begin
      bad++; $display("FAIL midrst_next_data msg=%h want=%h", o_msg, exp_field(500, 0));
    end
    // Reset while holding: o_valid must fall without waiting for a clock edge.
    rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL holdrst_o_valid got=%b want=0", o_valid); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
